mem_port_arbiter_rv32i: RTL
===========================

# mem_port_arbiter_rv32i

Two-requester arbiter and sequencer for the single unified memory port of the multicycle RV32I core. It shares the port between instruction fetch (IF) and data load/store (D). It latches one owner per transaction and drives the select of the 32-bit address/data multiplexer. It runs the valid/ready handshake toward memory and returns read data, completion and timeout error to the owning requester.

## Interface
- WIDTH, 32, address and data width
- TIMEOUT, 255, maximum BUSY cycles to wait for mem_ready before aborting; must be ≥1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  WIDTH  fetch address
- if_gnt  out  1  fetch owns the port (BUSY or RESP)
- if_done  out  1  one-cycle completion pulse to fetch
- if_err  out  1  qualifies if_done: transaction timed out
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wmask until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  WIDTH  data address
- d_wdata  in  WIDTH  store data
- d_wmask  in  4  byte write mask
- d_gnt / d_done / d_err  out  1 each  as for fetch
- rdata  out  WIDTH  registered read data; valid in the done cycle of the owner
- sel  out  1  current owner (0 = IF, 1 = D); drives the address mux
- mem_valid  out  1  request to memory
- mem_we  out  1  write strobe
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_wmask  out  4  byte mask; 4'b0000 for reads
- mem_ready  in  1  memory accepts/completes the current transfer
- mem_rdata  in  WIDTH  memory read data; sampled when mem_valid & mem_ready

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req, arbitrate, register sel = winner, assert gnt, go to BUSY. With no req, stay.
- BUSY:
  - mem_valid = 1.
  - On mem_ready: rdata ← mem_rdata (loads only; stores leave rdata unchanged), go to RESP.
  - Timeout: counter increments each BUSY cycle without mem_ready. On reaching TIMEOUT, err = 1, rdata ← 0, go to RESP.
- RESP: owner's done = 1 (and err if set) for exactly one cycle. Requests are ignored. Go to IDLE and clear err and the counter.
- A requester still asserting req in IDLE after its done starts a new transaction. Requesters deassert req in the done cycle to avoid this.
- mem_addr = sel ? d_addr : if_addr.
- mem_wdata = d_wdata.
- mem_we = mem_valid & sel & d_we.
- mem_wmask = mem_we ? d_wmask : 4'b0000.
- Non-owner gnt/done/err are 0 at all times.
- Tie rule (both req in IDLE): see Configuration.

## Timing
- Reset values: state IDLE, sel 0, both gnt 0, both done 0, both err 0, mem_valid 0, rdata 0, timeout counter 0, last-owner register 1 (D).
- Minimum transaction is 3 cycles: req seen at edge N; BUSY from N+1; mem_ready in the first BUSY cycle gives RESP (done) from N+2; IDLE from N+3.
- Each wait cycle of mem_ready adds one cycle.
- Timeout: done+err appear exactly TIMEOUT+1 cycles after BUSY entry.
- mem_ready arriving in the same cycle the counter reaches TIMEOUT: success wins, err = 0.
- mem_ready outside BUSY is ignored.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). No done is issued and the transaction is abandoned.
- Owner req dropping during BUSY is ignored; the transaction completes.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester that did not own the last completed transaction. A last-owner register updates on every RESP. After reset the first tie goes to IF.
- Undefined: fixed priority, D always wins ties. The last-owner register is not implemented.
- A single requester is granted immediately in both modes.

## Structure
- Shared package/header rv32i_arb_pkg: state encodings (IDLE 2'b00, BUSY 2'b01, RESP 2'b10), OWNER_IF = 1'b0, OWNER_D = 1'b1, default TIMEOUT.
- Sub-module: existing mux2to1_rv32i #(WIDTH) for mem_addr, selected by sel.
- Everything else lives in one module.

## Test plan
- Fetch only: if_req=1, if_addr=0x00000040, mem_ready=1, mem_rdata=0x00500093 → if_gnt in cycles 1–2, if_done in cycle 2, rdata=0x00500093, if_err=0.
- Store: d_req=1, d_we=1, d_addr=0x10000000, d_wdata=0xDEADBEEF, d_wmask=4'b1111, mem_ready delayed 3 cycles → mem_we=1 and mem_addr=0x10000000 for 4 BUSY cycles; d_done 1 cycle later; rdata unchanged.
- Tie: if_req=d_req=1 held for 3 transactions → without ARB_ROUND_ROBIN_EN, D,D,D; with it, IF,D,IF.
- Timeout: TIMEOUT=4, d_req load, mem_ready=0 → mem_valid high 5 cycles, then d_done=d_err=1, rdata=0.
- Reset mid-BUSY: assert rst_n=0 between clock edges → mem_valid, sel, gnt fall immediately; no done after release.
- Boundary: mem_ready rises in the cycle the counter hits TIMEOUT → done with err=0 and rdata=mem_rdata.

Source files
------------

// File: rtl/rv32i_arb_pkg.sv
// Shared encodings and helpers for the RV32I unified memory-port arbiter.
// State codes, owner codes, default timeout and the owner-selection function.
package rv32i_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

  // A lone requester always wins; tie_owner only decides when both request.
  function automatic logic pick_owner(input logic if_req, input logic d_req, input logic tie_owner);
    return d_req & (~if_req | tie_owner);
  endfunction

endpackage

// File: rtl/mux2to1_rv32i.sv
// Two-input word multiplexer used to steer the memory address between requesters.
module mux2to1_rv32i #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter_rv32i.sv
// Arbiter/sequencer sharing the single memory port between fetch and data access.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise data wins every tie.
module mem_port_arbiter_rv32i
  import rv32i_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_done,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_wmask,
  output logic             d_gnt,
  output logic             d_done,
  output logic             d_err,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       r_state, w_state_nxt;
  logic             r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_if_gnt, w_if_gnt_nxt;
  logic             r_d_gnt, w_d_gnt_nxt;
  logic             r_if_done, w_if_done_nxt;
  logic             r_d_done, w_d_done_nxt;
  logic             r_if_err, w_if_err_nxt;
  logic             r_d_err, w_d_err_nxt;
  logic             r_mem_valid, w_mem_valid_nxt;
  logic [WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic             w_tie_owner;
  logic             w_owner_store;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  // Remember who completed last so the next tie goes to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWNER_D;
    end else if (r_state == ST_RESP) begin
      r_last_owner <= r_sel;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  assign w_tie_owner = ~r_last_owner;
`else
  assign w_tie_owner = OWNER_D;
`endif

  assign w_owner_store = (r_sel == OWNER_D) & d_we;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_if_gnt_nxt    = r_if_gnt;
    w_d_gnt_nxt     = r_d_gnt;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_d_err_nxt     = 1'b0;
    w_mem_valid_nxt = r_mem_valid;
    w_rdata_nxt     = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (if_req | d_req) begin
          w_sel_nxt       = pick_owner(if_req, d_req, w_tie_owner);
          w_if_gnt_nxt    = ~w_sel_nxt;
          w_d_gnt_nxt     = w_sel_nxt;
          w_mem_valid_nxt = 1'b1;
          w_state_nxt     = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A ready in the final counted cycle still completes normally.
        if (mem_ready) begin
          if (!w_owner_store) begin
            w_rdata_nxt = mem_rdata;
          end else begin
            w_rdata_nxt = r_rdata;
          end
          w_if_done_nxt   = ~r_sel;
          w_d_done_nxt    = r_sel;
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = ST_RESP;
        end else if (r_cnt == CNT_MAX) begin
          w_rdata_nxt     = {WIDTH{1'b0}};
          w_if_done_nxt   = ~r_sel;
          w_d_done_nxt    = r_sel;
          w_if_err_nxt    = ~r_sel;
          w_d_err_nxt     = r_sel;
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        w_cnt_nxt    = {CNT_W{1'b0}};
        w_if_gnt_nxt = 1'b0;
        w_d_gnt_nxt  = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_cnt_nxt       = {CNT_W{1'b0}};
        w_if_gnt_nxt    = 1'b0;
        w_d_gnt_nxt     = 1'b0;
        w_mem_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered handshake outputs, owner, timeout counter and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= OWNER_IF;
      r_cnt       <= {CNT_W{1'b0}};
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_rdata     <= {WIDTH{1'b0}};
    end else begin
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_if_gnt    <= w_if_gnt_nxt;
      r_d_gnt     <= w_d_gnt_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_if_err    <= w_if_err_nxt;
      r_d_err     <= w_d_err_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  mux2to1_rv32i #(.WIDTH(WIDTH)) u_addr_mux (
    .i_a   (if_addr),
    .i_b   (d_addr),
    .i_sel (r_sel),
    .o_y   (mem_addr)
  );

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_err    = r_if_err;
  assign d_err     = r_d_err;
  assign sel       = r_sel;
  assign rdata     = r_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_valid & r_sel & d_we;
  assign mem_wdata = d_wdata;
  assign mem_wmask = mem_we ? d_wmask : 4'b0000;

endmodule
